// File: rtl/csr_neighbor_fetch.sv
// CSR graph store with round-robin vertex requests; streams each vertex's neighbour list
// from the edge memory into an output FIFO, with a runtime write port for graph updates.
module csr_neighbor_fetch #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned TAG_W      = 4,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned PTR_DEPTH  = 1024,
  parameter int unsigned EDGE_DEPTH = 1024,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic [NUM_CH-1:0]         req_valid,
  output logic [NUM_CH-1:0]         req_ready,
  input  logic [NUM_CH*32-1:0]      req_vertex,
  input  logic [NUM_CH*TAG_W-1:0]   req_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [$clog2(NUM_CH)-1:0] out_ch,
  output logic [TAG_W-1:0]          out_tag,
  output logic                      out_last,
  output logic                      out_nil,
  output logic                      out_err,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic                      wr_sel,
  input  logic [31:0]               wr_addr,
  input  logic [DATA_W-1:0]         wr_data,
  output logic                      busy
);

  localparam int unsigned CH_W    = $clog2(NUM_CH);
  localparam int unsigned PTR_AW  = $clog2(PTR_DEPTH);
  localparam int unsigned EDGE_AW = $clog2(EDGE_DEPTH);
  localparam int unsigned CUR_W   = EDGE_AW + 1;
  localparam int unsigned FIFO_AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = FIFO_AW + 1;
  localparam int unsigned SUM_W   = CNT_W + 1;
  localparam int unsigned ENT_W   = DATA_W + CH_W + TAG_W + 3;

  typedef enum logic [2:0] {StIdle, StPtrRd, StPtrWait, StStream, StDrain} state_e;

  state_e state_q, state_d;
  logic [CH_W-1:0]   rr_q;
  logic [PTR_AW-1:0] v_q;
  logic [CH_W-1:0]   ch_q;
  logic [TAG_W-1:0]  tag_q;
  logic              wait_q, wait_d;
  logic [CUR_W-1:0]  cur_q, cur_d, end_q, end_d;
  logic              iss_v1_q, iss_last1_q, iss_v2_q, iss_last2_q;
  logic              spec_v_q, spec_err_q;
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [DATA_W-1:0] ptr_mem  [PTR_DEPTH];
  logic [DATA_W-1:0] edge_mem [EDGE_DEPTH];
  logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] ptr_a_q1, ptr_b_q1, ptr_a_q2, ptr_b_q2;
  logic [DATA_W-1:0] edge_q1, edge_q2;

  logic              idle, wr_fire, ptr_we, edge_we;
  logic [SUM_W-1:0]  occupancy;
  logic              credit_ok, in_flight_zero;
  logic              grant_found, grant;
  logic [CH_W-1:0]   grant_idx, scan_idx;
  logic [31:0]       sel_vertex;
  logic [TAG_W-1:0]  sel_tag;
  logic              bad_v, bad_ptr, empty_list;
  logic [32:0]       v_plus1;
  logic [PTR_AW-1:0] ptr_a_addr, ptr_b_addr;
  logic              issue, issue_last, spec_push, spec_err;
  logic              push, pop;
  logic [ENT_W-1:0]  push_ent;
  logic              unused_vp;

  assign idle     = (state_q == StIdle);
  assign wr_ready = rst_n_in && idle;
  assign wr_fire  = wr_valid && wr_ready;
  assign ptr_we   = wr_fire && !wr_sel && (wr_addr < 32'(PTR_DEPTH));
  assign edge_we  = wr_fire && wr_sel && (wr_addr < 32'(EDGE_DEPTH));

  // Beats already committed to the FIFO plus those still in the read pipeline.
  assign occupancy = SUM_W'(cnt_q) + SUM_W'(iss_v1_q) + SUM_W'(iss_v2_q) + SUM_W'(spec_v_q);
  assign credit_ok = occupancy < SUM_W'(FIFO_DEPTH);
  assign in_flight_zero = !(iss_v1_q || iss_v2_q || spec_v_q);

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      scan_idx = CH_W'((32'(rr_q) + 32'(k)) % NUM_CH);
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  // Writes win in IDLE; a request also needs FIFO room since a bad vertex pushes at once.
  assign grant      = rst_n_in && idle && !wr_valid && credit_ok && grant_found;
  assign req_ready  = grant ? (NUM_CH'(1) << grant_idx) : '0;
  assign sel_vertex = req_vertex[32*grant_idx +: 32];
  assign sel_tag    = req_tag[TAG_W*grant_idx +: TAG_W];
  assign bad_v      = sel_vertex > 32'(PTR_DEPTH - 2);

  assign v_plus1    = {1'b0, 32'(v_q)} + 33'd1;
  assign unused_vp  = ^v_plus1[32:PTR_AW];
  assign ptr_a_addr = wr_fire ? wr_addr[PTR_AW-1:0] : v_q;
  assign ptr_b_addr = v_plus1[PTR_AW-1:0];

  assign bad_ptr    = (ptr_b_q2 > DATA_W'(EDGE_DEPTH)) || (ptr_b_q2 < ptr_a_q2);
  assign empty_list = (ptr_a_q2 == ptr_b_q2);

  always_comb begin
    state_d    = state_q;
    wait_d     = 1'b0;
    cur_d      = cur_q;
    end_d      = end_q;
    issue      = 1'b0;
    issue_last = 1'b0;
    spec_push  = 1'b0;
    spec_err   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant) begin
          if (bad_v) begin
            spec_push = 1'b1;
            spec_err  = 1'b1;
          end else begin
            state_d = StPtrRd;
          end
        end
      end
      StPtrRd: state_d = StPtrWait;
      StPtrWait: begin
        wait_d = !wait_q;
        if (wait_q) begin
          cur_d = ptr_a_q2[CUR_W-1:0];
          end_d = ptr_b_q2[CUR_W-1:0];
          if (bad_ptr) begin
            spec_push = 1'b1;
            spec_err  = 1'b1;
            state_d   = StDrain;
          end else if (empty_list) begin
            spec_push = 1'b1;
            state_d   = StDrain;
          end else begin
            state_d = StStream;
          end
        end
      end
      StStream: begin
        if (credit_ok) begin
          issue = 1'b1;
          cur_d = cur_q + CUR_W'(1);
          if (cur_q == end_q - CUR_W'(1)) begin
            issue_last = 1'b1;
            state_d    = StDrain;
          end
        end
      end
      StDrain: if (in_flight_zero) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (ptr_we) ptr_mem[ptr_a_addr] <= wr_data;
    ptr_a_q1 <= ptr_mem[ptr_a_addr];
    ptr_b_q1 <= ptr_mem[ptr_b_addr];
    ptr_a_q2 <= ptr_a_q1;
    ptr_b_q2 <= ptr_b_q1;
  end

  always_ff @(posedge clk_in) begin
    if (edge_we) edge_mem[wr_addr[EDGE_AW-1:0]] <= wr_data;
    edge_q1 <= edge_mem[cur_q[EDGE_AW-1:0]];
    edge_q2 <= edge_q1;
  end

  assign push = iss_v2_q || spec_v_q;
  assign pop  = out_valid && out_ready;
  // Entry layout: {err, nil, last, tag, ch, data}.
  assign push_ent = spec_v_q ? {spec_err_q, !spec_err_q, 1'b1, tag_q, ch_q, DATA_W'(0)}
                             : {1'b0, 1'b0, iss_last2_q, tag_q, ch_q, edge_q2};

  always_ff @(posedge clk_in) begin
    if (push) fifo_mem[wr_ptr_q] <= push_ent;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= StIdle;
      rr_q        <= '0;
      v_q         <= '0;
      ch_q        <= '0;
      tag_q       <= '0;
      wait_q      <= 1'b0;
      cur_q       <= '0;
      end_q       <= '0;
      iss_v1_q    <= 1'b0;
      iss_last1_q <= 1'b0;
      iss_v2_q    <= 1'b0;
      iss_last2_q <= 1'b0;
      spec_v_q    <= 1'b0;
      spec_err_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      cur_q       <= cur_d;
      end_q       <= end_d;
      iss_v1_q    <= issue;
      iss_last1_q <= issue_last;
      iss_v2_q    <= iss_v1_q;
      iss_last2_q <= iss_last1_q;
      spec_v_q    <= spec_push;
      spec_err_q  <= spec_err;
      if (grant) begin
        rr_q  <= CH_W'((32'(grant_idx) + 32'd1) % NUM_CH);
        v_q   <= sel_vertex[PTR_AW-1:0];
        ch_q  <= grant_idx;
        tag_q <= sel_tag;
      end
      if (push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign out_valid = (cnt_q != '0);
  assign {out_err, out_nil, out_last, out_tag, out_ch, out_data} =
      out_valid ? fifo_mem[rd_ptr_q] : '0;
  assign busy = !idle || out_valid || spec_v_q;

endmodule

// File: tb/tb_csr_neighbor_fetch.sv
// Directed bench for csr_neighbor_fetch: table of single requests plus sequences for
// arbitration, back-pressure, write priority and mid-stream reset.
module tb_csr_neighbor_fetch;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   req_valid, req_ready;
  logic [127:0] req_vertex;
  logic [15:0]  req_tag;
  logic         out_valid, out_ready;
  logic [31:0]  out_data;
  logic [1:0]   out_ch;
  logic [3:0]   out_tag;
  logic         out_last, out_nil, out_err;
  logic         wr_valid, wr_ready, wr_sel;
  logic [31:0]  wr_addr, wr_data;
  logic         busy;

  always #5 clk = ~clk;

  csr_neighbor_fetch dut (
    .clk_in     (clk),
    .rst_n_in   (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_vertex (req_vertex),
    .req_tag    (req_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ch     (out_ch),
    .out_tag    (out_tag),
    .out_last   (out_last),
    .out_nil    (out_nil),
    .out_err    (out_err),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_sel     (wr_sel),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endfunction

  typedef struct {
    logic [31:0] data;
    logic [1:0]  ch;
    logic [3:0]  tag;
    logic        last, nil, err;
    int          cyc;
  } beat_t;

  beat_t       got_q[$];
  logic        stall_prev = 1'b0;
  logic [41:0] prev_out = '0;

  // Beats are captured at the falling edge; they transfer on the following rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev)
        chk("stable_while_stalled",
            {out_valid, out_err, out_nil, out_last, out_tag, out_ch, out_data}, prev_out);
      if (out_valid && out_ready)
        got_q.push_back('{out_data, out_ch, out_tag, out_last, out_nil, out_err, cyc});
      stall_prev = out_valid && !out_ready;
      prev_out   = {out_valid, out_err, out_nil, out_last, out_tag, out_ch, out_data};
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic do_write(input logic sel, input logic [31:0] addr, input logic [31:0] data);
    int n = 0;
    wr_valid = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
    @(negedge clk);
    while (!wr_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wr_accept", wr_ready, 1);
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  task automatic do_req(input int ch, input logic [31:0] v, input logic [3:0] tag,
                        output int acc);
    int n = 0;
    req_vertex[32*ch +: 32] = v;
    req_tag[4*ch +: 4] = tag;
    req_valid[ch] = 1'b1;
    @(negedge clk);
    while (!req_ready[ch] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("req_accept", req_ready[ch], 1);
    acc = cyc;
    @(posedge clk); #1;
    req_valid[ch] = 1'b0;
  endtask

  // Waits for n beats, then lingers to catch any extra or duplicated beat.
  task automatic wait_beats(input int n, input int budget);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    repeat (12) @(posedge clk);
    #1;
    chk("beat_count", got_q.size(), n);
  endtask

  task automatic cmp_beat(input string name, input int j, input logic [31:0] d,
                          input logic [1:0] ch, input logic [3:0] tag, input logic last,
                          input logic nil, input logic err);
    if (j < got_q.size())
      chk(name, {got_q[j].err, got_q[j].nil, got_q[j].last, got_q[j].tag, got_q[j].ch,
                 got_q[j].data}, {err, nil, last, tag, ch, d});
  endtask

  typedef struct {
    int          ch;
    logic [31:0] v;
    logic [3:0]  tag;
    int          n;
    logic [31:0] d[3];
    logic        nil, err;
    int          lat;
  } vec_t;

  vec_t tbl[8];

  function automatic void set_vec(input int i, input int ch, input logic [31:0] v,
                                  input logic [3:0] tag, input int n, input logic [31:0] d0,
                                  input logic [31:0] d1, input logic [31:0] d2,
                                  input logic nil, input logic err, input int lat);
    tbl[i].ch = ch; tbl[i].v = v; tbl[i].tag = tag; tbl[i].n = n;
    tbl[i].d[0] = d0; tbl[i].d[1] = d1; tbl[i].d[2] = d2;
    tbl[i].nil = nil; tbl[i].err = err; tbl[i].lat = lat;
  endfunction

  int          acc;
  int          gorder[4];
  int          gcnt;
  logic [3:0]  rdy_snap;
  logic [31:0] rr_data[10];
  logic [1:0]  rr_ch[10];
  logic        rr_last[10];

  initial begin
    set_vec(0, 0, 32'd0,    4'd5,  3, 32'd7,      32'd8, 32'd9, 1'b0, 1'b0, 7);
    set_vec(1, 1, 32'd1,    4'd2,  1, 32'd0,      32'd0, 32'd0, 1'b1, 1'b0, 0);
    set_vec(2, 2, 32'd1023, 4'd3,  1, 32'd0,      32'd0, 32'd0, 1'b0, 1'b1, 2);
    set_vec(3, 3, 32'd2,    4'd9,  2, 32'd4,      32'd2, 32'd0, 1'b0, 1'b0, 0);
    set_vec(4, 1, 32'd1022, 4'd1,  1, 32'd0,      32'd0, 32'd0, 1'b1, 1'b0, 0);
    set_vec(5, 2, 32'd5,    4'd6,  1, 32'd0,      32'd0, 32'd0, 1'b0, 1'b1, 0);
    set_vec(6, 0, 32'd7,    4'hA,  1, 32'hABCD,   32'd0, 32'd0, 1'b0, 1'b0, 0);
    set_vec(7, 3, 32'd0,    4'hC,  3, 32'd7,      32'd8, 32'd9, 1'b0, 1'b0, 7);

    // Reset held with requests and a write pending: every output must stay low.
    req_valid = 4'hF; req_vertex = '0; req_tag = '0; out_ready = 1'b1;
    wr_valid = 1'b1; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    req_valid = '0; wr_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_write(0, 0, 0);    do_write(0, 1, 3);    do_write(0, 2, 3);    do_write(0, 3, 5);
    do_write(0, 4, 6);    do_write(0, 5, 0);    do_write(0, 6, 1025); do_write(0, 7, 1023);
    do_write(0, 8, 1024); do_write(0, 9, 10);   do_write(0, 10, 22);
    do_write(0, 1022, 5); do_write(0, 1023, 5);
    do_write(1, 0, 7); do_write(1, 1, 8); do_write(1, 2, 9); do_write(1, 3, 4);
    do_write(1, 4, 2); do_write(1, 5, 2); do_write(1, 1023, 32'hABCD);
    for (int i = 0; i < 12; i++) do_write(1, 32'(10 + i), 32'(100 + i));
    // Out-of-range writes must be dropped rather than aliasing onto entry 0.
    do_write(0, 1024, 99);
    do_write(1, 1024, 55);

    for (int i = 0; i < 8; i++) begin
      got_q.delete();
      do_req(tbl[i].ch, tbl[i].v, tbl[i].tag, acc);
      wait_beats(tbl[i].n, 60);
      for (int j = 0; j < tbl[i].n; j++)
        cmp_beat($sformatf("vec%0d_beat%0d", i, j), j,
                 (tbl[i].nil || tbl[i].err) ? 32'd0 : tbl[i].d[j], 2'(tbl[i].ch), tbl[i].tag,
                 j == tbl[i].n - 1, tbl[i].nil, tbl[i].err);
      if (tbl[i].lat != 0 && got_q.size() > 0)
        chk($sformatf("vec%0d_latency", i), got_q[0].cyc - acc, tbl[i].lat);
    end

    // All four channels at once: grants go 0,1,2,3 and streams arrive unbroken.
    got_q.delete();
    req_vertex = {32'd2, 32'd0, 32'd2, 32'd0};
    req_tag    = {4'd4, 4'd3, 4'd2, 4'd1};
    req_valid  = 4'hF;
    gcnt = 0;
    for (int n = 0; n < 300 && req_valid != 0; n++) begin
      @(negedge clk);
      rdy_snap = req_ready;
      for (int k = 0; k < 4; k++)
        if (rdy_snap[k] && gcnt < 4) begin
          gorder[gcnt] = k;
          gcnt++;
        end
      @(posedge clk); #1;
      req_valid = req_valid & ~rdy_snap;
    end
    chk("rr_grant_count", gcnt, 4);
    for (int k = 0; k < 4; k++) chk($sformatf("rr_grant%0d", k), gorder[k], k);
    wait_beats(10, 150);
    rr_data = '{7, 8, 9, 4, 2, 7, 8, 9, 4, 2};
    rr_ch   = '{0, 0, 0, 1, 1, 2, 2, 2, 3, 3};
    rr_last = '{0, 0, 1, 0, 1, 0, 0, 1, 0, 1};
    for (int j = 0; j < 10; j++)
      cmp_beat($sformatf("rr_beat%0d", j), j, rr_data[j], rr_ch[j], 4'(rr_ch[j] + 1),
               rr_last[j], 1'b0, 1'b0);

    // Pointer wrapped to 0: with ch0 and ch1 both asking, ch0 goes first.
    got_q.delete();
    req_vertex = {32'd0, 32'd0, 32'd1023, 32'd1023};
    req_valid  = 4'b0011;
    gcnt = 0;
    for (int n = 0; n < 100 && req_valid != 0; n++) begin
      @(negedge clk);
      rdy_snap = req_ready;
      for (int k = 0; k < 4; k++)
        if (rdy_snap[k] && gcnt < 4) begin
          gorder[gcnt] = k;
          gcnt++;
        end
      @(posedge clk); #1;
      req_valid = req_valid & ~rdy_snap;
    end
    chk("wrap_grant_count", gcnt, 2);
    chk("wrap_first", gorder[0], 0);
    wait_beats(2, 40);

    // Back-pressure on a 12-beat list: toggle, then hold low long enough to fill the FIFO.
    got_q.delete();
    do_req(2, 32'd9, 4'd7, acc);
    for (int k = 0; k < 10; k++) begin
      out_ready = ~out_ready;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_beats(12, 100);
    for (int j = 0; j < 12; j++)
      cmp_beat($sformatf("bp_beat%0d", j), j, 32'(100 + j), 2'd2, 4'd7, j == 11, 1'b0, 1'b0);

    // Write and request together in IDLE: the write wins, the request then sees it.
    got_q.delete();
    wr_valid = 1'b1; wr_sel = 1'b0; wr_addr = 1; wr_data = 4;
    req_vertex[31:0] = 0; req_tag[3:0] = 4'd6; req_valid[0] = 1'b1;
    @(negedge clk);
    chk("wr_priority_wr_ready", wr_ready, 1);
    chk("wr_priority_req_ready", req_ready, 0);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    req_valid[0] = 1'b0;
    do_req(0, 32'd0, 4'd6, acc);
    wait_beats(4, 60);
    rr_data[0:3] = '{7, 8, 9, 4};
    for (int j = 0; j < 4; j++)
      cmp_beat($sformatf("wrq_beat%0d", j), j, rr_data[j], 2'd0, 4'd6, j == 3, 1'b0, 1'b0);

    // One-cycle reset in the middle of a stream.
    got_q.delete();
    do_req(1, 32'd9, 4'd3, acc);
    for (int n = 0; n < 60 && got_q.size() < 3; n++) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_wr_ready", wr_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_busy", busy, 0);
    chk("postrst_out_valid", out_valid, 0);
    @(posedge clk); #1;
    got_q.delete();
    do_req(0, 32'd3, 4'd8, acc);
    wait_beats(1, 60);
    cmp_beat("postrst_v3", 0, 32'd2, 2'd0, 4'd8, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
